// File: rtl/isp_awb_gray.sv
// rtl/isp_awb_gray.sv - gray-world auto-white-balance statistics and R/B gain engine
module isp_awb_gray #(
    parameter int BITS       = 8,
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 960,
    parameter int SUM_BITS   = 32,
    parameter int CNT_BITS   = 24,
    parameter int SAT_THRESH = 250,
    parameter int MIN_PIXELS = 1024
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            awb_en,
    input  logic [7:0]      man_gain_r,
    input  logic [7:0]      man_gain_g,
    input  logic [7:0]      man_gain_b,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_r,
    input  logic [BITS-1:0] in_g,
    input  logic [BITS-1:0] in_b,
    output logic [7:0]      gain_r,
    output logic [7:0]      gain_g,
    output logic [7:0]      gain_b,
    output logic            gain_valid,
    output logic            busy
);

    // Working width of the divider: numerator is sum_g<<4 and the saturation
    // test compares against den<<8, so SUM_BITS+8 holds every intermediate.
    localparam int DW = SUM_BITS + 8;
    localparam logic [BITS:0]     SAT_T   = (BITS+1)'(SAT_THRESH);
    localparam logic [CNT_BITS-1:0] MIN_CNT = CNT_BITS'(MIN_PIXELS);
    localparam logic [7:0]        GAIN_ONE = 8'd16;

    // The accumulators must hold a full frame of maximum-valued pixels.
    if (SUM_BITS < BITS + $clog2(WIDTH * HEIGHT)) begin : g_sum_bits_check
        $error("isp_awb_gray: SUM_BITS too small for WIDTH*HEIGHT");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_UPDATE
    } state_t;

    state_t              state_q, state_d;
    logic                vsync_q;
    logic [SUM_BITS-1:0] sum_r_q, sum_g_q, sum_b_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [DW-1:0]       rem_r_q, rem_b_q;
    logic [SUM_BITS-1:0] den_r_q, den_b_q;
    logic [CNT_BITS-1:0] cnt_l_q;
    logic [3:0]          div_cnt_q;
    logic [7:0]          quo_r_q, quo_b_q;
    logic                sat_r_q, sat_b_q;

    logic                pix_ok;
    logic                frame_start;
    logic                frame_end;
    logic [2:0]          bit_idx;
    logic [DW-1:0]       trial_r, trial_b;

    function automatic logic [SUM_BITS-1:0] sat_add(input logic [SUM_BITS-1:0] a,
                                                    input logic [BITS-1:0]     b);
        logic [SUM_BITS:0] s;
        s = {1'b0, a} + (SUM_BITS+1)'(b);
        return s[SUM_BITS] ? '1 : s[SUM_BITS-1:0];
    endfunction

    assign pix_ok = in_href & in_vsync &
                    ({1'b0, in_r} < SAT_T) & ({1'b0, in_g} < SAT_T) & ({1'b0, in_b} < SAT_T);
    assign frame_start = in_vsync & ~vsync_q;
    assign frame_end   = ~in_vsync & vsync_q;

    // Per-frame statistics: first vsync cycle reloads, later valid pixels accumulate with saturation.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
            cnt_q   <= '0;
        end else begin
            vsync_q <= in_vsync;
            if (frame_start) begin
                sum_r_q <= pix_ok ? SUM_BITS'(in_r) : '0;
                sum_g_q <= pix_ok ? SUM_BITS'(in_g) : '0;
                sum_b_q <= pix_ok ? SUM_BITS'(in_b) : '0;
                cnt_q   <= CNT_BITS'(pix_ok);
            end else if (pix_ok) begin
                sum_r_q <= sat_add(sum_r_q, in_r);
                sum_g_q <= sat_add(sum_g_q, in_g);
                sum_b_q <= sat_add(sum_b_q, in_b);
                cnt_q   <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and busy: a frame end is only accepted while idle; DIV runs 9 cycles.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_end) begin
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                busy = 1'b1;
                if (div_cnt_q == 4'd8) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busy    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Trial subtrahends for the current quotient bit (div cycles 1..8 give bits 7..0).
    always_comb begin
        bit_idx = 3'(4'd8 - div_cnt_q);
        trial_r = DW'(den_r_q) << bit_idx;
        trial_b = DW'(den_b_q) << bit_idx;
    end

    // Divider datapath and gain registers; manual gains override every cycle when AWB is off.
    always_ff @(posedge pclk) begin
        if (rst) begin
            rem_r_q    <= '0;
            rem_b_q    <= '0;
            den_r_q    <= '0;
            den_b_q    <= '0;
            cnt_l_q    <= '0;
            div_cnt_q  <= '0;
            quo_r_q    <= '0;
            quo_b_q    <= '0;
            sat_r_q    <= 1'b0;
            sat_b_q    <= 1'b0;
            gain_r     <= GAIN_ONE;
            gain_g     <= GAIN_ONE;
            gain_b     <= GAIN_ONE;
            gain_valid <= 1'b0;
        end else begin
            gain_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_end) begin
                        rem_r_q   <= DW'({sum_g_q, 4'b0000});
                        rem_b_q   <= DW'({sum_g_q, 4'b0000});
                        den_r_q   <= sum_r_q;
                        den_b_q   <= sum_b_q;
                        cnt_l_q   <= cnt_q;
                        div_cnt_q <= '0;
                        quo_r_q   <= '0;
                        quo_b_q   <= '0;
                    end
                end
                S_DIV: begin
                    div_cnt_q <= div_cnt_q + 4'd1;
                    if (div_cnt_q == 4'd0) begin
                        // A quotient of 256 or more cannot be represented in 4.4.
                        sat_r_q <= (den_r_q == '0) || (rem_r_q >= (DW'(den_r_q) << 8));
                        sat_b_q <= (den_b_q == '0) || (rem_b_q >= (DW'(den_b_q) << 8));
                    end else begin
                        if (rem_r_q >= trial_r) begin
                            rem_r_q          <= rem_r_q - trial_r;
                            quo_r_q[bit_idx] <= 1'b1;
                        end
                        if (rem_b_q >= trial_b) begin
                            rem_b_q          <= rem_b_q - trial_b;
                            quo_b_q[bit_idx] <= 1'b1;
                        end
                    end
                end
                S_UPDATE: begin
                    if (awb_en && (cnt_l_q >= MIN_CNT)) begin
                        if (den_r_q != '0) begin
                            gain_r <= sat_r_q ? 8'hff : quo_r_q;
                        end
                        if (den_b_q != '0) begin
                            gain_b <= sat_b_q ? 8'hff : quo_b_q;
                        end
                        gain_g     <= GAIN_ONE;
                        gain_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (!awb_en) begin
                gain_r <= man_gain_r;
                gain_g <= man_gain_g;
                gain_b <= man_gain_b;
            end
        end
    end

endmodule

// File: tb/tb_isp_awb_gray.sv
// tb/tb_isp_awb_gray.sv - scoreboard bench for isp_awb_gray
module tb_isp_awb_gray;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       awb_en = 1'b1;
    logic [7:0] man_gain_r = 8'd16;
    logic [7:0] man_gain_g = 8'd16;
    logic [7:0] man_gain_b = 8'd16;
    logic       in_href = 1'b0;
    logic       in_vsync = 1'b0;
    logic [7:0] in_r = '0;
    logic [7:0] in_g = '0;
    logic [7:0] in_b = '0;
    logic [7:0] gain_r, gain_g, gain_b;
    logic       gain_valid, busy;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       v;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_r = 16, exp_g = 16, exp_b = 16;

    isp_awb_gray #(
        .BITS(8), .WIDTH(8), .HEIGHT(4), .SUM_BITS(32), .CNT_BITS(24),
        .SAT_THRESH(250), .MIN_PIXELS(16)
    ) dut (
        .pclk(pclk), .rst(rst), .awb_en(awb_en),
        .man_gain_r(man_gain_r), .man_gain_g(man_gain_g), .man_gain_b(man_gain_b),
        .in_href(in_href), .in_vsync(in_vsync),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b),
        .gain_valid(gain_valid), .busy(busy)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic pix(input int mode, input int col, output logic [7:0] r,
                       output logic [7:0] g, output logic [7:0] b);
        case (mode)
            0: begin r = 8'd64;  g = 8'd128; b = 8'd32;  end
            1: begin r = 8'd4;   g = 8'd128; b = 8'd128; end
            2: begin r = (col % 2 == 0) ? 8'd255 : 8'd100; g = 8'd100; b = 8'd100; end
            default: begin r = 8'd50; g = 8'd250; b = 8'd50; end
        endcase
    endtask

    // Drives one 8x4 frame, models the statistics, pushes the expected outcome.
    task automatic drive_frame(input int mode);
        longint sr = 0, sg = 0, sb_ = 0, cnt = 0, num;
        logic [7:0] r, g, b;
        exp_t e;
        tick();
        in_vsync = 1'b1;
        in_href  = 1'b0;
        tick();
        tick();
        for (int line = 0; line < 4; line++) begin
            for (int col = 0; col < 8; col++) begin
                pix(mode, col, r, g, b);
                in_href = 1'b1;
                in_r = r; in_g = g; in_b = b;
                if (r < 250 && g < 250 && b < 250) begin
                    sr += r; sg += g; sb_ += b; cnt++;
                end
                tick();
            end
            in_href = 1'b0;
            tick();
            tick();
        end
        in_vsync = 1'b0;
        num = sg * 16;
        e.v = 1'b0;
        if (awb_en && cnt >= 16) begin
            if (sr != 0) exp_r = (num >= sr * 256) ? 255 : int'(num / sr);
            if (sb_ != 0) exp_b = (num >= sb_ * 256) ? 255 : int'(num / sb_);
            exp_g = 16;
            e.v = 1'b1;
        end
        e.r = 8'(exp_r); e.g = 8'(exp_g); e.b = 8'(exp_b);
        sb.push_back(e);
    endtask

    // Follows the frame-end edge for a bounded window and compares against the scoreboard.
    task automatic wait_result(input string name);
        exp_t e;
        int first = 0, pulses = 0;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        tick();
        check({name, "_busy_div"}, busy, 1);
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (gain_valid) begin
                pulses++;
                if (first == 0) first = n;
            end
        end
        if (e.v) begin
            check({name, "_valid_latency"}, first, 10);
            check({name, "_valid_pulses"}, pulses, 1);
        end else begin
            check({name, "_no_valid"}, pulses, 0);
        end
        check({name, "_gain_r"}, gain_r, e.r);
        check({name, "_gain_g"}, gain_g, e.g);
        check({name, "_gain_b"}, gain_b, e.b);
        check({name, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("rst_gain_r", gain_r, 16);
        check("rst_gain_g", gain_g, 16);
        check("rst_gain_b", gain_b, 16);
        check("rst_valid", gain_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        drive_frame(0); wait_result("uniform");
        drive_frame(1); wait_result("sat_r");
        drive_frame(3); wait_result("few_pixels");
        drive_frame(2); wait_result("excluded");

        awb_en = 1'b0;
        man_gain_r = 8'd20; man_gain_g = 8'd16; man_gain_b = 8'd40;
        exp_r = 20; exp_g = 16; exp_b = 40;
        tick();
        check("man_gain_r", gain_r, 20);
        check("man_gain_g", gain_g, 16);
        check("man_gain_b", gain_b, 40);
        drive_frame(0); wait_result("manual");
        awb_en = 1'b1;
        tick();
        check("hold_gain_r", gain_r, 20);
        check("hold_gain_b", gain_b, 40);
        drive_frame(0); wait_result("auto_again");

        drive_frame(1);
        void'(sb.pop_front());
        tick();
        repeat (4) tick();
        check("div_busy_before_rst", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_r = 16; exp_g = 16; exp_b = 16;
        check("abort_gain_r", gain_r, 16);
        check("abort_gain_g", gain_g, 16);
        check("abort_gain_b", gain_b, 16);
        check("abort_busy", busy, 0);
        check("abort_valid", gain_valid, 0);
        tick();
        drive_frame(0); wait_result("after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
